// File: rtl/udp_tx_arbiter.sv
// Two-source round-robin arbiter that latches one packet at a time and presents it to a UDP TX
// engine, with per-packet timeout, inter-packet gap and saturating delivery/drop statistics.
module udp_tx_arbiter #(
    parameter int DATA_W     = 7680,
    parameter int TIMEOUT    = 50000,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    input  logic [15:0]       s0_length,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    input  logic [15:0]       s1_length,
    output logic              s1_ready,
    output logic              udp_send_data_valid,
    input  logic              udp_send_data_ready,
    output logic [DATA_W-1:0] udp_send_data,
    output logic [15:0]       udp_send_data_length,
    output logic              grant_id,
    output logic [15:0]       sent_cnt0,
    output logic [15:0]       sent_cnt1,
    output logic [15:0]       drop_cnt,
    output logic              timeout_pulse
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              last_grant;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic              sel;
    logic [15:0]       sel_length;
    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic              zero_len;
    logic              ready_hit;
    logic              timeout_hit;
    logic              gap_done;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // On contention the source that did not win last time is chosen.
    always_comb begin
        sel         = (s0_valid && s1_valid) ? ~last_grant : s1_valid;
        sel_length  = sel ? s1_length : s0_length;
        sel_data    = sel ? s1_data : s0_data;
        accept      = (state == IDLE) && (s0_valid || s1_valid);
        zero_len    = (sel_length == 16'd0);
        s0_ready    = rst_n && accept && !sel;
        s1_ready    = rst_n && accept && sel;
        ready_hit   = (state == SEND) && udp_send_data_ready;
        timeout_hit = (state == SEND) && !udp_send_data_ready && (wait_cnt == WAIT_LAST);
        gap_done    = (state == GAP) && (gap_cnt == GAP_LAST);
        udp_send_data_valid = (state == SEND);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = zero_len ? GAP : SEND;
            SEND: if (ready_hit || timeout_hit) state_nxt = GAP;
            GAP:  if (gap_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            timeout_pulse <= 1'b0;
            wait_cnt      <= '0;
            gap_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            timeout_pulse <= timeout_hit;
            if (accept)
                last_grant <= sel;
            if (accept)
                wait_cnt <= '0;
            else if (state == SEND && !udp_send_data_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

    // Packet registers only load on acceptance, so they stay frozen through SEND and GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            udp_send_data        <= '0;
            udp_send_data_length <= '0;
            grant_id             <= 1'b0;
        end else if (accept) begin
            udp_send_data        <= sel_data;
            udp_send_data_length <= sel_length;
            grant_id             <= sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt0 <= '0;
            sent_cnt1 <= '0;
            drop_cnt  <= '0;
        end else begin
            if (ready_hit && !grant_id)
                sent_cnt0 <= sat_inc(sent_cnt0);
            if (ready_hit && grant_id)
                sent_cnt1 <= sat_inc(sent_cnt1);
            if ((accept && zero_len) || timeout_hit)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: reset, contention, single packet, timeout,
// ready on the last timeout cycle, zero-length drop and asynchronous reset mid-packet.
module tb_udp_tx_arbiter;

    localparam int DATA_W     = 64;
    localparam int TIMEOUT    = 8;
    localparam int GAP_CYCLES = 4;

    localparam logic [DATA_W-1:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [DATA_W-1:0] D1 = 64'hFEDC_BA98_7654_3210;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s0_valid = 1'b0;
    logic [DATA_W-1:0] s0_data = D0;
    logic [15:0]       s0_length = 16'd0;
    logic              s0_ready;
    logic              s1_valid = 1'b0;
    logic [DATA_W-1:0] s1_data = D1;
    logic [15:0]       s1_length = 16'd0;
    logic              s1_ready;
    logic              udp_send_data_valid;
    logic              udp_send_data_ready = 1'b0;
    logic [DATA_W-1:0] udp_send_data;
    logic [15:0]       udp_send_data_length;
    logic              grant_id;
    logic [15:0]       sent_cnt0;
    logic [15:0]       sent_cnt1;
    logic [15:0]       drop_cnt;
    logic              timeout_pulse;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_sent0 = 16'd0;
    logic [15:0] exp_sent1 = 16'd0;
    logic [15:0] exp_drop = 16'd0;

    udp_tx_arbiter #(
        .DATA_W(DATA_W),
        .TIMEOUT(TIMEOUT),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s0_valid(s0_valid),
        .s0_data(s0_data),
        .s0_length(s0_length),
        .s0_ready(s0_ready),
        .s1_valid(s1_valid),
        .s1_data(s1_data),
        .s1_length(s1_length),
        .s1_ready(s1_ready),
        .udp_send_data_valid(udp_send_data_valid),
        .udp_send_data_ready(udp_send_data_ready),
        .udp_send_data(udp_send_data),
        .udp_send_data_length(udp_send_data_length),
        .grant_id(grant_id),
        .sent_cnt0(sent_cnt0),
        .sent_cnt1(sent_cnt1),
        .drop_cnt(drop_cnt),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        s0_length = 16'd5;
        s1_length = 16'd5;
        step();
        step();
        n_cmp++; if (s0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s0_ready: got %b want 0", s0_ready); end
        n_cmp++; if (s1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s1_ready: got %b want 0", s1_ready); end
        n_cmp++; if (udp_send_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", udp_send_data_valid); end
        n_cmp++; if (udp_send_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", udp_send_data); end
        n_cmp++; if (udp_send_data_length !== 16'd0) begin n_fail++; $display("FAIL reset_length: got %0d want 0", udp_send_data_length); end
        n_cmp++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant_id); end
        n_cmp++; if ({sent_cnt0, sent_cnt1, drop_cnt} !== 48'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", sent_cnt0, sent_cnt1, drop_cnt); end
        n_cmp++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_pulse: got %b want 0", timeout_pulse); end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_contention;
        logic g;
        s0_data = D0;
        s1_data = D1;
        s0_length = 16'd100;
        s1_length = 16'd200;
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        udp_send_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g = i[0];
            #1;
            n_cmp++; if ({s1_ready, s0_ready} !== (g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contention_ready[%0d]: got s1/s0=%b%b want %s", i, s1_ready, s0_ready, g ? "10" : "01"); end
            step();
            n_cmp++; if (udp_send_data_valid !== 1'b1 || grant_id !== g) begin n_fail++; $display("FAIL contention_grant[%0d]: got valid=%b grant=%b want valid=1 grant=%b", i, udp_send_data_valid, grant_id, g); end
            n_cmp++; if (udp_send_data !== (g ? D1 : D0) || udp_send_data_length !== (g ? 16'd200 : 16'd100)) begin n_fail++; $display("FAIL contention_payload[%0d]: got %h/%0d", i, udp_send_data, udp_send_data_length); end
            if (g) exp_sent1++; else exp_sent0++;
            step();
            n_cmp++; if (udp_send_data_valid !== 1'b0) begin n_fail++; $display("FAIL contention_gap_valid[%0d]: got %b want 0", i, udp_send_data_valid); end
            repeat (GAP_CYCLES - 1) step();
            n_cmp++; if ({s1_ready, s0_ready} !== 2'b00) begin n_fail++; $display("FAIL contention_gap_ready[%0d]: got s1/s0=%b%b want 00", i, s1_ready, s0_ready); end
            step();
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        udp_send_data_ready = 1'b0;
        n_cmp++; if (sent_cnt0 !== exp_sent0 || sent_cnt1 !== exp_sent1) begin n_fail++; $display("FAIL contention_counts: got %0d/%0d want %0d/%0d", sent_cnt0, sent_cnt1, exp_sent0, exp_sent1); end
    endtask

    task automatic test_single;
        s0_data = D0;
        s0_length = 16'd960;
        s0_valid = 1'b1;
        #1;
        n_cmp++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL single_accept: got s0=%b s1=%b want 1/0", s0_ready, s1_ready); end
        step();
        s0_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) udp_send_data_ready = 1'b1;
            #1;
            n_cmp++; if (udp_send_data_valid !== 1'b1 || s0_ready !== 1'b0) begin n_fail++; $display("FAIL single_send_c%0d: got valid=%b s0_ready=%b want 1/0", c, udp_send_data_valid, s0_ready); end
            if (c == 1) begin
                n_cmp++; if (udp_send_data !== D0 || udp_send_data_length !== 16'd960 || grant_id !== 1'b0) begin n_fail++; $display("FAIL single_latch: got %h/%0d/%b", udp_send_data, udp_send_data_length, grant_id); end
            end
            step();
        end
        udp_send_data_ready = 1'b0;
        exp_sent0++;
        n_cmp++; if (sent_cnt0 !== exp_sent0) begin n_fail++; $display("FAIL single_sent0: got %0d want %0d", sent_cnt0, exp_sent0); end
        s0_valid = 1'b1;
        for (int c = 4; c <= 7; c++) begin
            #1;
            n_cmp++; if (udp_send_data_valid !== 1'b0 || s0_ready !== 1'b0) begin n_fail++; $display("FAIL single_gap_c%0d: got valid=%b s0_ready=%b want 0/0", c, udp_send_data_valid, s0_ready); end
            step();
        end
        #1;
        n_cmp++; if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL single_idle_c8: got s0_ready=%b want 1", s0_ready); end
        udp_send_data_ready = 1'b1;
        step();
        s0_valid = 1'b0;
        n_cmp++; if (udp_send_data_valid !== 1'b1) begin n_fail++; $display("FAIL single_held_send: got %b want 1", udp_send_data_valid); end
        step();
        udp_send_data_ready = 1'b0;
        exp_sent0++;
        n_cmp++; if (sent_cnt0 !== exp_sent0 || udp_send_data_valid !== 1'b0) begin n_fail++; $display("FAIL single_held_done: got cnt=%0d valid=%b want %0d/0", sent_cnt0, udp_send_data_valid, exp_sent0); end
        repeat (GAP_CYCLES) step();
    endtask

    task automatic test_timeout;
        s1_length = 16'd50;
        s1_valid = 1'b1;
        #1;
        n_cmp++; if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_accept: got s1=%b s0=%b want 1/0", s1_ready, s0_ready); end
        step();
        s1_valid = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            n_cmp++; if (udp_send_data_valid !== 1'b1 || timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL timeout_wait_c%0d: got valid=%b pulse=%b want 1/0", c, udp_send_data_valid, timeout_pulse); end
            step();
        end
        exp_drop++;
        n_cmp++; if (udp_send_data_valid !== 1'b0 || timeout_pulse !== 1'b1) begin n_fail++; $display("FAIL timeout_fire: got valid=%b pulse=%b want 0/1", udp_send_data_valid, timeout_pulse); end
        n_cmp++; if (drop_cnt !== exp_drop || sent_cnt0 !== exp_sent0 || sent_cnt1 !== exp_sent1) begin n_fail++; $display("FAIL timeout_counts: got drop=%0d sent=%0d/%0d want %0d %0d/%0d", drop_cnt, sent_cnt0, sent_cnt1, exp_drop, exp_sent0, exp_sent1); end
        step();
        n_cmp++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b want 0", timeout_pulse); end
        repeat (GAP_CYCLES - 1) step();
    endtask

    task automatic test_ready_last;
        s0_length = 16'd10;
        s0_valid = 1'b1;
        step();
        s0_valid = 1'b0;
        for (int c = 1; c < TIMEOUT; c++) step();
        udp_send_data_ready = 1'b1;
        #1;
        n_cmp++; if (udp_send_data_valid !== 1'b1) begin n_fail++; $display("FAIL ready_last_valid: got %b want 1", udp_send_data_valid); end
        step();
        udp_send_data_ready = 1'b0;
        exp_sent0++;
        n_cmp++; if (sent_cnt0 !== exp_sent0 || drop_cnt !== exp_drop) begin n_fail++; $display("FAIL ready_last_counts: got sent0=%0d drop=%0d want %0d/%0d", sent_cnt0, drop_cnt, exp_sent0, exp_drop); end
        n_cmp++; if (timeout_pulse !== 1'b0 || udp_send_data_valid !== 1'b0) begin n_fail++; $display("FAIL ready_last_pulse: got pulse=%b valid=%b want 0/0", timeout_pulse, udp_send_data_valid); end
        step();
        n_cmp++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL ready_last_pulse_late: got %b want 0", timeout_pulse); end
        repeat (GAP_CYCLES - 1) step();
    endtask

    task automatic test_zero_len;
        s1_length = 16'd0;
        s1_valid = 1'b1;
        #1;
        n_cmp++; if (s1_ready !== 1'b1) begin n_fail++; $display("FAIL zero_accept: got %b want 1", s1_ready); end
        step();
        s1_valid = 1'b0;
        exp_drop++;
        n_cmp++; if (drop_cnt !== exp_drop || sent_cnt1 !== exp_sent1) begin n_fail++; $display("FAIL zero_counts: got drop=%0d sent1=%0d want %0d/%0d", drop_cnt, sent_cnt1, exp_drop, exp_sent1); end
        for (int c = 1; c <= GAP_CYCLES; c++) begin
            n_cmp++; if (udp_send_data_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid_c%0d: got %b want 0", c, udp_send_data_valid); end
            step();
        end
    endtask

    task automatic test_async_reset;
        s0_length = 16'd77;
        s0_valid = 1'b1;
        step();
        s0_valid = 1'b0;
        step();
        n_cmp++; if (udp_send_data_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b want 1", udp_send_data_valid); end
        rst_n = 1'b0;
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        s1_length = 16'd33;
        #1;
        n_cmp++; if (udp_send_data_valid !== 1'b0 || timeout_pulse !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl: got valid=%b pulse=%b rdy=%b%b want 0", udp_send_data_valid, timeout_pulse, s0_ready, s1_ready); end
        n_cmp++; if (udp_send_data !== '0 || udp_send_data_length !== 16'd0 || grant_id !== 1'b0) begin n_fail++; $display("FAIL arst_data: got %h/%0d/%b want 0", udp_send_data, udp_send_data_length, grant_id); end
        n_cmp++; if ({sent_cnt0, sent_cnt1, drop_cnt} !== 48'd0) begin n_fail++; $display("FAIL arst_counters: got %0d/%0d/%0d want 0", sent_cnt0, sent_cnt1, drop_cnt); end
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++; if ({s1_ready, s0_ready} !== 2'b01) begin n_fail++; $display("FAIL arst_first_grant: got s1/s0=%b%b want 01", s1_ready, s0_ready); end
        udp_send_data_ready = 1'b1;
        step();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        n_cmp++; if (udp_send_data_valid !== 1'b1 || grant_id !== 1'b0 || udp_send_data_length !== 16'd77) begin n_fail++; $display("FAIL arst_resend: got valid=%b grant=%b len=%0d want 1/0/77", udp_send_data_valid, grant_id, udp_send_data_length); end
        step();
        udp_send_data_ready = 1'b0;
        n_cmp++; if (sent_cnt0 !== 16'd1 || sent_cnt1 !== 16'd0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_post_counts: got %0d/%0d/%0d want 1/0/0", sent_cnt0, sent_cnt1, drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_timeout();
        test_ready_last();
        test_zero_len();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
